// File: rtl/operand_stack_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : operand_stack_pkg
//  Brief   : Strobe encodings for the operand stack {push,pop,tos} decode.
//  Rev     : 1.0  initial release
// ============================================================================
package operand_stack_pkg;

   localparam logic [2:0] C_OP_NONE     = 3'b000;
   localparam logic [2:0] C_OP_TOS      = 3'b001;
   localparam logic [2:0] C_OP_POP      = 3'b010;
   localparam logic [2:0] C_OP_POP_TOS  = 3'b011;
   localparam logic [2:0] C_OP_PUSH     = 3'b100;
   localparam logic [2:0] C_OP_PUSH_TOS = 3'b101;
   localparam logic [2:0] C_OP_REPL     = 3'b110;
   localparam logic [2:0] C_OP_REPL_TOS = 3'b111;

endpackage
`default_nettype wire

// File: rtl/operand_stack_ram.sv
`default_nettype none
// ============================================================================
//  Module  : stack_ram
//  Brief   : DEPTH x WIDTH register file, one sync write port, one async read.
//  Rev     : 1.0  initial release
// ============================================================================
module stack_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we && ({1'b0, waddr} < C_DEPTH))
         r_mem[waddr] <= wdata;
   end

   // Non-power-of-two depths leave unused addresses; they read as zero.
   assign rdata = ({1'b0, raddr} < C_DEPTH) ? r_mem[raddr] : '0;

endmodule
`default_nettype wire

// File: rtl/operand_stack.sv
`default_nettype none
// ============================================================================
//  Module  : operand_stack
//  Brief   : LIFO operand stack with registered output and sticky error flags.
//  Rev     : 1.0  initial release
// ============================================================================
module operand_stack
   import operand_stack_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       tos,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       stack_empty,
   output logic                       stack_full,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int              SW       = $clog2(DEPTH+1);
   localparam int              AW       = $clog2(DEPTH);
   localparam logic [SW-1:0]   C_DEPTH  = SW'(DEPTH);

   logic [SW-1:0]    r_sp;
   logic [WIDTH-1:0] r_dout;
   logic             r_overflow;
   logic             r_underflow;

   logic [2:0]       w_op;
   logic             w_empty;
   logic             w_full;
   logic [AW-1:0]    w_top_idx;
   logic [WIDTH-1:0] w_rdata;
   logic             w_we;
   logic [AW-1:0]    w_waddr;
   logic [SW-1:0]    w_sp_nxt;
   logic [WIDTH-1:0] w_dout_nxt;
   logic             w_ovf_set;
   logic             w_unf_set;

   assign w_op      = {push, pop, tos};
   assign w_empty   = (r_sp == '0);
   assign w_full    = (r_sp == C_DEPTH);
   assign w_top_idx = AW'(r_sp - 1'b1);

   stack_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (w_we),
      .waddr (w_waddr),
      .wdata (din),
      .raddr (w_top_idx),
      .rdata (w_rdata)
   );

   // The read port is asynchronous, so w_rdata is always the pre-edge top;
   // that gives replace and push&tos their read-before-write ordering.
   always_comb begin
      w_sp_nxt   = r_sp;
      w_dout_nxt = r_dout;
      w_ovf_set  = 1'b0;
      w_unf_set  = 1'b0;
      w_we       = 1'b0;
      w_waddr    = AW'(r_sp);
      case (w_op)
         C_OP_REPL, C_OP_REPL_TOS: begin
            w_we = 1'b1;
            if (!w_empty) begin
               w_dout_nxt = w_rdata;
               w_waddr    = w_top_idx;
            end else begin
               w_sp_nxt  = r_sp + 1'b1;
               w_unf_set = 1'b1;
            end
         end
         C_OP_PUSH, C_OP_PUSH_TOS: begin
            if (w_op == C_OP_PUSH_TOS) begin
               if (!w_empty) w_dout_nxt = w_rdata;
               else          w_unf_set  = 1'b1;
            end
            if (!w_full) begin
               w_we     = 1'b1;
               w_sp_nxt = r_sp + 1'b1;
            end else begin
               w_ovf_set = 1'b1;
            end
         end
         C_OP_POP, C_OP_POP_TOS: begin
            if (!w_empty) begin
               w_dout_nxt = w_rdata;
               w_sp_nxt   = r_sp - 1'b1;
            end else begin
               w_unf_set = 1'b1;
            end
         end
         C_OP_TOS: begin
            if (!w_empty) w_dout_nxt = w_rdata;
            else          w_unf_set  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sp        <= '0;
         r_dout      <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_sp        <= w_sp_nxt;
         r_dout      <= w_dout_nxt;
         r_overflow  <= r_overflow  | w_ovf_set;
         r_underflow <= r_underflow | w_unf_set;
      end
   end

   assign dout        = r_dout;
   assign count       = r_sp;
   assign stack_empty = w_empty;
   assign stack_full  = w_full;
   assign overflow    = r_overflow;
   assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_operand_stack.sv
`default_nettype none
// ============================================================================
//  Module  : tb_operand_stack
//  Brief   : Directed self-checking bench for operand_stack (WIDTH=8, DEPTH=16).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_operand_stack;

   logic       clk = 1'b0;
   logic       rst;
   logic       push, pop, tos;
   logic [7:0] din;
   logic [7:0] dout;
   logic       stack_empty, stack_full, overflow, underflow;
   logic [4:0] count;

   int n_checks = 0;
   int n_errors = 0;

   operand_stack #(.WIDTH(8), .DEPTH(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .pop         (pop),
      .tos         (tos),
      .din         (din),
      .dout        (dout),
      .stack_empty (stack_empty),
      .stack_full  (stack_full),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one strobe set for exactly one rising edge, then sample 1ns later.
   task automatic op(input logic p, input logic po, input logic t, input logic [7:0] d);
      push = p; pop = po; tos = t; din = d;
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; tos = 1'b0;
   endtask

   initial begin
      rst = 1'b1; push = 1'b0; pop = 1'b0; tos = 1'b0; din = 8'h00;
      #2;
      chk("rst_dout", dout, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", stack_empty, 1);
      chk("rst_full", stack_full, 0);
      @(negedge clk); rst = 1'b0;

      // 1: dirty the state, then reset asynchronously mid-cycle
      op(0, 1, 0, 8'h00);
      chk("t1_unf_pre", underflow, 1);
      op(1, 0, 0, 8'hA1);
      op(1, 0, 0, 8'hA2);
      op(1, 0, 0, 8'hA3);
      op(0, 0, 1, 8'h00);
      chk("t1_dout_pre", dout, 8'hA3);
      chk("t1_count_pre", count, 3);
      #2 rst = 1'b1;
      #1;
      chk("t1_dout", dout, 0);
      chk("t1_count", count, 0);
      chk("t1_empty", stack_empty, 1);
      chk("t1_unf", underflow, 0);
      chk("t1_ovf", overflow, 0);
      @(negedge clk); rst = 1'b0;

      // 2: LIFO ordering
      op(1, 0, 0, 8'h11);
      op(1, 0, 0, 8'h22);
      op(1, 0, 0, 8'h33);
      chk("t2_count3", count, 3);
      op(0, 1, 0, 8'h00); chk("t2_pop1", dout, 8'h33);
      op(0, 1, 0, 8'h00); chk("t2_pop2", dout, 8'h22);
      op(0, 1, 0, 8'h00); chk("t2_pop3", dout, 8'h11);
      chk("t2_empty", stack_empty, 1);

      // 3: tos peeks without removing
      op(1, 0, 0, 8'h5A);
      op(0, 0, 1, 8'h00); chk("t3_tos1", dout, 8'h5A); chk("t3_cnt1", count, 1);
      op(0, 0, 1, 8'h00); chk("t3_tos2", dout, 8'h5A); chk("t3_cnt2", count, 1);
      chk("t3_empty", stack_empty, 0);
      op(0, 1, 0, 8'h00); chk("t3_pop", count, 0);

      // 4: fill, overflow, and blocked write
      for (int i = 0; i < 16; i++) op(1, 0, 0, 8'hA0 + 8'(i));
      chk("t4_full", stack_full, 1);
      chk("t4_ovf_pre", overflow, 0);
      op(1, 0, 0, 8'hFF);
      chk("t4_ovf", overflow, 1);
      chk("t4_count", count, 16);
      op(0, 1, 0, 8'h00);
      chk("t4_pop_top", dout, 8'hAF);
      chk("t4_notfull", stack_full, 0);
      for (int i = 0; i < 15; i++) op(0, 1, 0, 8'h00);
      chk("t4_bottom", dout, 8'hA0);
      chk("t4_drained", count, 0);

      // 5: underflow on empty, sticky through later pushes
      op(0, 1, 0, 8'h00);
      chk("t5_unf", underflow, 1);
      chk("t5_dout_hold", dout, 8'hA0);
      chk("t5_count", count, 0);
      op(1, 0, 0, 8'h07);
      chk("t5_count1", count, 1);
      chk("t5_unf_sticky", underflow, 1);
      chk("t5_ovf_sticky", overflow, 1);
      op(0, 1, 0, 8'h00);
      chk("t5_pop", dout, 8'h07);

      // 6: replace top with push&pop
      op(1, 0, 0, 8'h01);
      op(1, 0, 0, 8'h02);
      op(1, 1, 0, 8'h09);
      chk("t6_repl_dout", dout, 8'h02);
      chk("t6_repl_cnt", count, 2);
      op(0, 1, 0, 8'h00); chk("t6_pop1", dout, 8'h09);
      op(0, 1, 0, 8'h00); chk("t6_pop2", dout, 8'h01);
      chk("t6_empty", stack_empty, 1);

      // push&tos: old top to dout, then push
      op(1, 0, 0, 8'h44);
      op(1, 0, 1, 8'h55);
      chk("pt_dout", dout, 8'h44);
      chk("pt_count", count, 2);
      op(0, 1, 0, 8'h00); chk("pt_pop", dout, 8'h55);
      op(0, 1, 0, 8'h00);

      // push&pop on empty after a fresh reset: acts as push, flags underflow
      rst = 1'b1; #1;
      @(negedge clk); rst = 1'b0;
      op(1, 1, 0, 8'h66);
      chk("pe_unf", underflow, 1);
      chk("pe_count", count, 1);
      chk("pe_dout", dout, 8'h00);
      op(0, 1, 0, 8'h00);
      chk("pe_pop", dout, 8'h66);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
